riscv_processor: RTL and testbench
==================================

// Module: riscv_processor
// PURPOSE
//   Single-cycle RV64I subset core (ld, sd, add, sub, and, or, addi, beq) with built-in instruction ROM,
//   32x64 register file and 256-byte data RAM. Top of the CPU; all datapath/control nets are exported
//   as outputs for waveform/bench inspection. One instruction retires per rising clk edge.
// PARAMETERS
//   DMEM_BYTES  256  data RAM size in bytes (doubleword-addressed, little-endian)
//   IMEM_BYTES  64   instruction ROM size in bytes; fetch beyond end returns 32'h0
// PORTS
//   clk             in   1   clock, all state updates on rising edge
//   reset           in   1   synchronous, active-high reset
//   PC_In           out  64  next-PC mux output
//   PC_Out          out  64  current PC register
//   ReadData1/2     out  64  regfile read ports (rs1/rs2)
//   WriteData       out  64  regfile write data (MemtoReg ? Read_Data : Result)
//   Result          out  64  ALU result
//   Read_Data       out  64  data RAM read (0 when MemRead=0)
//   imm_data        out  64  sign-extended immediate (unshifted)
//   Instruction     out  32  fetched word at PC_Out
//   opcode          out  7   Instruction[6:0]
//   rs1, rs2, rd    out  5   Instruction[19:15], [24:20], [11:7]
//   ALUOp           out  2   00 add, 01 sub, 10 R-type decode
//   adder_out1      out  64  PC_Out + 4
//   adder_out2      out  64  PC_Out + (imm_data << 1)
//   Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite  out 1 each  main control signals
//   addermuxselect  out  1   Branch & (ALU zero); selects adder_out2 as PC_In
//   index0..index4  out  64  data RAM doublewords at byte addresses 0, 8, 16, 24, 32
// BEHAVIOUR
//   Reset (sync, edge with reset=1): PC=0; regs x[i]=0; data RAM all 0. Outputs then follow comb logic.
//   Control by opcode: R 0110011 {RegWrite,ALUOp=10}; addi 0010011 {ALUSrc,RegWrite,ALUOp=00};
//     ld 0000011 {ALUSrc,MemtoReg,RegWrite,MemRead,ALUOp=00}; sd 0100011 {ALUSrc,MemWrite,ALUOp=00};
//     beq 1100011 {Branch,ALUOp=01}; any other opcode (incl. 0) -> all controls 0 (NOP, PC+4).
//   ALU control: ALUOp 00 add; 01 sub; 10: funct7[5]/funct3 0/000 add, 1/000 sub, x/111 and, x/110 or,
//     others add. 64-bit wraparound arithmetic; zero = (Result==0).
//   Imm: I [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8]}; sign-extended to 64; others 0.
//   ALU B operand = ALUSrc ? imm_data : ReadData2. PC_In = addermuxselect ? adder_out2 : adder_out1.
//   Edge: PC<=PC_In; if RegWrite & rd!=0 reg[rd]<=WriteData; x0 reads 0 always.
//   Edge: if MemWrite RAM[Result[7:3]] <= ReadData2 (addr low 3 bits ignored; out of range wraps mod size).
//   Read_Data combinational from same address. Reads see pre-edge state (no write-through).
// CONFIGURATION
//   RISCV_BNE_EN: defined -> opcode 1100011 funct3 001 (bne) uses addermuxselect = Branch & ~zero;
//   undefined -> funct3 ignored, every 1100011 behaves as beq.
// STRUCTURE
//   Package riscv_pkg: opcode constants, ALUOp codes, 4-bit ALU ctrl codes (add 0010, sub 0110, and 0000,
//   or 0001). Sub-module riscv_alu64 (a, b, ctrl -> result, zero). ROM/regfile/RAM inline.
//   Built-in ROM (byte addr: instr): 00 addi x1,x0,5; 04 addi x2,x0,3; 08 add x3,x1,x2; 0C sub x4,x1,x2;
//   10 sd x3,0(x0); 14 sd x4,8(x0); 18 ld x5,8(x0); 1C beq x5,x4,+8; 20 addi x6,x0,1; 24 and x7,x1,x2;
//   28 or x8,x1,x2; 2C sd x8,16(x0); 30 beq x0,x0,0 (halt loop).
// TESTING
//   Reset 1 cycle -> PC_Out=0, Instruction=0x00500093, imm_data=5, ALUSrc=RegWrite=1, index0..4=0.
//   Run 8 cycles -> x3=8, x4=2 visible as ReadData via later reads; index0=8, index1=2.
//   At PC=0x1C -> Branch=1, Result=0, addermuxselect=1, PC_In=0x24; x6 never written (stays 0).
//   After PC=0x30 reached -> index2=7 (or 5|3), PC_Out stuck at 0x30, adder_out2=0x30.
//   Assert reset mid-program -> next edge PC=0, index0..4=0, program re-executes identically.
//   RISCV_BNE_EN build: bne instruction with equal operands -> addermuxselect=0, PC_In=PC+4.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and decode helpers for the single-cycle RV64I subset core.
package riscv_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_ctrl_e;

    typedef struct packed {
        logic    branch;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    reg_write;
        alu_op_e alu_op;
    } ctrl_t;

    // Unknown opcodes (including an all-zero word) decode to a NOP that falls through to PC+4.
    function automatic ctrl_t decode_ctrl(input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_REG: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_RTYPE;
            end
            OP_IMM: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_LOAD: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
            end
            OP_STORE: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                c.branch = 1'b1;
                c.alu_op = ALUOP_SUB;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic alu_ctrl_e alu_ctrl(input alu_op_e op, input logic f7_5, input logic [2:0] f3);
        case (op)
            ALUOP_ADD: return ALU_ADD;
            ALUOP_SUB: return ALU_SUB;
            ALUOP_RTYPE: begin
                case (f3)
                    3'b000:  return f7_5 ? ALU_SUB : ALU_ADD;
                    3'b111:  return ALU_AND;
                    3'b110:  return ALU_OR;
                    default: return ALU_ADD;
                endcase
            end
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu64.sv
// 64-bit ALU: add/sub/and/or with wraparound arithmetic and a zero flag.
import riscv_pkg::*;

module riscv_alu64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [3:0]  ctrl,
    output logic [63:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            default: result = a + b;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/riscv_processor.sv
// Single-cycle RV64I subset core with built-in ROM, register file and data RAM.
// Optional RISCV_BNE_EN: funct3=001 on the branch opcode inverts the taken condition (bne).
import riscv_pkg::*;

module riscv_processor #(
    parameter int unsigned DMEM_BYTES = 256,
    parameter int unsigned IMEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] PC_In,
    output logic [63:0] PC_Out,
    output logic [63:0] ReadData1,
    output logic [63:0] ReadData2,
    output logic [63:0] WriteData,
    output logic [63:0] Result,
    output logic [63:0] Read_Data,
    output logic [63:0] imm_data,
    output logic [31:0] Instruction,
    output logic [6:0]  opcode,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [1:0]  ALUOp,
    output logic [63:0] adder_out1,
    output logic [63:0] adder_out2,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        addermuxselect,
    output logic [63:0] index0,
    output logic [63:0] index1,
    output logic [63:0] index2,
    output logic [63:0] index3,
    output logic [63:0] index4
);

    localparam int unsigned DMEM_WORDS = DMEM_BYTES / 8;
    localparam int unsigned DMEM_AW    = $clog2(DMEM_WORDS);

    logic [63:0]        regs [32];
    logic [63:0]        dmem [DMEM_WORDS];
    logic [DMEM_AW-1:0] dmem_idx;
    ctrl_t              ctrl;
    logic               alu_zero;
    logic [63:0]        alu_b;

    always_comb begin
        Instruction = '0;
        if (PC_Out < 64'(IMEM_BYTES)) begin
            case (PC_Out[5:2])
                4'h0:    Instruction = 32'h00500093;
                4'h1:    Instruction = 32'h00300113;
                4'h2:    Instruction = 32'h002081B3;
                4'h3:    Instruction = 32'h40208233;
                4'h4:    Instruction = 32'h00303023;
                4'h5:    Instruction = 32'h00403423;
                4'h6:    Instruction = 32'h00803283;
                4'h7:    Instruction = 32'h00428463;
                4'h8:    Instruction = 32'h00100313;
                4'h9:    Instruction = 32'h0020F3B3;
                4'hA:    Instruction = 32'h0020E433;
                4'hB:    Instruction = 32'h00803823;
                4'hC:    Instruction = 32'h00000063;
                default: Instruction = '0;
            endcase
        end
    end

    assign opcode = Instruction[6:0];
    assign rs1    = Instruction[19:15];
    assign rs2    = Instruction[24:20];
    assign rd     = Instruction[11:7];

    assign ctrl     = decode_ctrl(opcode);
    assign Branch   = ctrl.branch;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign MemtoReg = ctrl.mem_to_reg;
    assign ALUSrc   = ctrl.alu_src;
    assign RegWrite = ctrl.reg_write;
    assign ALUOp    = ctrl.alu_op;

    // Branch immediate is kept as offset/2; the target adder applies the shift.
    always_comb begin
        imm_data = '0;
        case (opcode)
            OP_IMM, OP_LOAD: imm_data = {{52{Instruction[31]}}, Instruction[31:20]};
            OP_STORE:        imm_data = {{52{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
            OP_BRANCH:       imm_data = {{52{Instruction[31]}}, Instruction[31], Instruction[7],
                                         Instruction[30:25], Instruction[11:8]};
            default:         imm_data = '0;
        endcase
    end

    assign ReadData1 = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign ReadData2 = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign alu_b     = ALUSrc ? imm_data : ReadData2;

    riscv_alu64 u_alu (
        .a      (ReadData1),
        .b      (alu_b),
        .ctrl   (alu_ctrl(ctrl.alu_op, Instruction[30], Instruction[14:12])),
        .result (Result),
        .zero   (alu_zero)
    );

    assign dmem_idx  = Result[DMEM_AW+2:3];
    assign Read_Data = MemRead ? dmem[dmem_idx] : '0;
    assign WriteData = MemtoReg ? Read_Data : Result;

    assign adder_out1 = PC_Out + 64'd4;
    assign adder_out2 = PC_Out + (imm_data << 1);

`ifdef RISCV_BNE_EN
    assign addermuxselect = Branch & ((Instruction[14:12] == 3'b001) ? ~alu_zero : alu_zero);
`else
    assign addermuxselect = Branch & alu_zero;
`endif

    assign PC_In = addermuxselect ? adder_out2 : adder_out1;

    always_ff @(posedge clk) begin
        if (reset) begin
            PC_Out <= '0;
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
            for (int unsigned i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
        end else begin
            PC_Out <= PC_In;
            if (RegWrite && (rd != 5'd0)) regs[rd] <= WriteData;
            if (MemWrite) dmem[dmem_idx] <= ReadData2;
        end
    end

    assign index0 = dmem[0];
    assign index1 = dmem[1];
    assign index2 = dmem[2];
    assign index3 = dmem[3];
    assign index4 = dmem[4];

endmodule

// File: tb/tb_riscv_processor.sv
// Directed bench for riscv_processor: expectations queued per step, checked after each state settles.
module tb_riscv_processor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] PC_In, PC_Out, ReadData1, ReadData2, WriteData, Result, Read_Data, imm_data;
    logic [31:0] Instruction;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  ALUOp;
    logic [63:0] adder_out1, adder_out2;
    logic        Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, addermuxselect;
    logic [63:0] index0, index1, index2, index3, index4;

    riscv_processor #(.DMEM_BYTES(256), .IMEM_BYTES(64)) dut (
        .clk(clk), .reset(reset), .PC_In(PC_In), .PC_Out(PC_Out),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteData(WriteData),
        .Result(Result), .Read_Data(Read_Data), .imm_data(imm_data),
        .Instruction(Instruction), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
        .ALUOp(ALUOp), .adder_out1(adder_out1), .adder_out2(adder_out2),
        .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .ALUSrc(ALUSrc), .RegWrite(RegWrite), .addermuxselect(addermuxselect),
        .index0(index0), .index1(index1), .index2(index2), .index3(index3), .index4(index4)
    );

    always #5 clk = ~clk;

    typedef enum int {
        S_PC, S_PCIN, S_INSTR, S_IMM, S_ALUSRC, S_REGWRITE, S_RD1, S_RD2, S_RESULT,
        S_BRANCH, S_AMS, S_WD, S_RDATA, S_MEMREAD, S_ADD2, S_ALUOP,
        S_IDX0, S_IDX1, S_IDX2, S_IDX3, S_IDX4
    } sig_e;

    typedef struct {
        sig_e        sig;
        logic [63:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [63:0] exp_pc [12] = '{64'h00, 64'h04, 64'h08, 64'h0C, 64'h10, 64'h14,
                                 64'h18, 64'h1C, 64'h24, 64'h28, 64'h2C, 64'h30};

    function automatic logic [31:0] rom_word(input logic [63:0] pc);
        case (pc)
            64'h00:  return 32'h00500093;
            64'h04:  return 32'h00300113;
            64'h08:  return 32'h002081B3;
            64'h0C:  return 32'h40208233;
            64'h10:  return 32'h00303023;
            64'h14:  return 32'h00403423;
            64'h18:  return 32'h00803283;
            64'h1C:  return 32'h00428463;
            64'h20:  return 32'h00100313;
            64'h24:  return 32'h0020F3B3;
            64'h28:  return 32'h0020E433;
            64'h2C:  return 32'h00803823;
            64'h30:  return 32'h00000063;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] observe(input sig_e s);
        case (s)
            S_PC:       return PC_Out;
            S_PCIN:     return PC_In;
            S_INSTR:    return {32'h0, Instruction};
            S_IMM:      return imm_data;
            S_ALUSRC:   return {63'h0, ALUSrc};
            S_REGWRITE: return {63'h0, RegWrite};
            S_RD1:      return ReadData1;
            S_RD2:      return ReadData2;
            S_RESULT:   return Result;
            S_BRANCH:   return {63'h0, Branch};
            S_AMS:      return {63'h0, addermuxselect};
            S_WD:       return WriteData;
            S_RDATA:    return Read_Data;
            S_MEMREAD:  return {63'h0, MemRead};
            S_ADD2:     return adder_out2;
            S_ALUOP:    return {62'h0, ALUOp};
            S_IDX0:     return index0;
            S_IDX1:     return index1;
            S_IDX2:     return index2;
            S_IDX3:     return index3;
            S_IDX4:     return index4;
            default:    return 64'hx;
        endcase
    endfunction

    task automatic push(input sig_e s, input logic [63:0] v, input string t);
        exp_t e;
        e.sig = s;
        e.exp = v;
        e.tag = t;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [63:0] got;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = observe(e.sig);
            checks++;
            assert (got === e.exp) else begin
                errors++;
                $error("FAIL %s @PC=%h: got %h expected %h", e.tag, PC_Out, got, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_check();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push(S_PC, 64'h0, "rst_pc");
        push(S_INSTR, 64'h00500093, "rst_instr");
        push(S_IMM, 64'd5, "rst_imm");
        push(S_ALUSRC, 64'd1, "rst_alusrc");
        push(S_REGWRITE, 64'd1, "rst_regwrite");
        push(S_IDX0, 64'h0, "rst_idx0");
        push(S_IDX1, 64'h0, "rst_idx1");
        push(S_IDX2, 64'h0, "rst_idx2");
        push(S_IDX3, 64'h0, "rst_idx3");
        push(S_IDX4, 64'h0, "rst_idx4");
        drain();
    endtask

    task automatic run_program(input int n);
        logic [63:0] pc;
        for (int s = 0; s < n; s++) begin
            pc = (s < 12) ? exp_pc[s] : 64'h30;
            push(S_PC, pc, "pc");
            push(S_INSTR, {32'h0, rom_word(pc)}, "instr");
            case (pc)
                64'h00: begin push(S_WD, 64'd5, "addi_x1"); push(S_PCIN, 64'h04, "pcin0"); end
                64'h04: push(S_WD, 64'd3, "addi_x2");
                64'h08: begin push(S_RESULT, 64'd8, "add"); push(S_ALUOP, 64'd2, "aluop_r"); end
                64'h0C: push(S_RESULT, 64'd2, "sub");
                64'h10: begin push(S_RD2, 64'd8, "sd_x3"); push(S_RESULT, 64'd0, "sd_addr0"); end
                64'h14: begin push(S_RD2, 64'd2, "sd_x4"); push(S_IDX0, 64'd8, "idx0"); end
                64'h18: begin
                    push(S_MEMREAD, 64'd1, "ld_memread");
                    push(S_RDATA, 64'd2, "ld_data");
                    push(S_WD, 64'd2, "ld_wd");
                    push(S_IDX1, 64'd2, "idx1");
                end
                64'h1C: begin
                    push(S_BRANCH, 64'd1, "beq_branch");
                    push(S_RD1, 64'd2, "beq_x5");
                    push(S_RESULT, 64'd0, "beq_result");
                    push(S_AMS, 64'd1, "beq_taken");
                    push(S_PCIN, 64'h24, "beq_target");
                    push(S_RDATA, 64'd0, "rdata_gated");
                end
                64'h24: push(S_RESULT, 64'd1, "and");
                64'h28: push(S_RESULT, 64'd7, "or");
                64'h30: begin
                    push(S_IDX2, 64'd7, "idx2");
                    push(S_ADD2, 64'h30, "halt_add2");
                    push(S_PCIN, 64'h30, "halt_pcin");
                    push(S_IDX3, 64'd0, "idx3_untouched");
                end
                default: ;
            endcase
            drain();
            tick();
        end
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        reset_and_check();
        run_program(15);
        reset_and_check();
        run_program(6);
        reset_and_check();
        run_program(13);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
